fc_vec_packer: RTL and testbench

//  Stream-to-vector packer that builds the flattened activation bus for a fully-connected layer.

---
 rtl/fc_vec_packer.sv | 125 ++++++++++++
 tb/tb_fc_vec_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_vec_packer.sv
// ---------------------------------------------------------------------------
// fc_vec_packer
//
// Purpose:
//   Collects N signed words arriving one at a time on a valid/ready stream and
//   presents them as a single flattened BIT_WIDTH*N vector to the
//   fully-connected dot-product stage. There is a single buffer, so filling
//   and presenting never overlap. When a vector completes, the packer holds it
//   until the downstream stage accepts it.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_valid  input word valid
//   s_ready  packer can accept a word (registered state decode)
//   s_data   input element; stored bit-exact, no sign handling needed
//   s_last   marks the final element of a vector
//   m_valid  packed vector valid (registered, independent of m_ready)
//   m_ready  downstream accepts the vector
//   m_data   flattened vector, element k at [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
//   err_len  one-cycle pulse on a vector length violation
//
// FSM states:
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | accepting words into slot cnt_q, m_valid low
//   FULL  | complete vector on m_data, waiting for m_ready, s_ready low
// ---------------------------------------------------------------------------
module fc_vec_packer #(
    parameter int BIT_WIDTH = 32,
    parameter int N         = 120
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [BIT_WIDTH-1:0]   s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BIT_WIDTH*N-1:0] m_data,
    output logic                   err_len
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   s_ready_q;
    logic                   m_valid_q;
    logic                   err_len_q;
    logic [BIT_WIDTH*N-1:0] slots_q;

    logic in_xfer;
    logic out_xfer;
    logic at_last;

    assign in_xfer  = s_valid && s_ready_q;
    assign out_xfer = m_valid_q && m_ready;
    assign at_last  = (cnt_q == LAST_IDX);

    // The register already reads 1 during a held reset (it is set by the
    // first reset edge), so it is masked to keep upstream stalled until
    // reset is released.
    assign s_ready = s_ready_q && !rst;
    assign m_valid = m_valid_q;
    assign m_data  = slots_q;
    assign err_len = err_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            err_len_q <= 1'b0;
            slots_q   <= '0;
        end else begin
            err_len_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (in_xfer) begin
                        slots_q[int'(cnt_q)*BIT_WIDTH +: BIT_WIDTH] <= s_data;
                        if (at_last) begin
                            // The slot count closes the vector even without
                            // s_last. The next word starts a new vector.
                            state_q   <= FULL;
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                            err_len_q <= !s_last;
                        end else if (s_last) begin
                            // Runt vector: restart at slot 0. Stale slot
                            // contents are overwritten by the next vector.
                            cnt_q     <= '0;
                            err_len_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_q   <= FILL;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    cnt_q     <= '0;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_vec_packer.sv
module tb_fc_vec_packer;

    localparam int BW = 32;
    localparam int NN = 120;
    localparam int GUARD = 4 * NN + 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [BW-1:0]    s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [BW*NN-1:0] m_data;
    logic             err_len;

    int n_checks = 0;
    int n_errors = 0;
    int n_vec_in = 0;
    int n_vec_out = 0;

    // Reference model: accepted words of the vector in progress, and
    // completed vectors not yet taken by the downstream side.
    logic [BW-1:0]    cur_q[$];
    logic [BW*NN-1:0] exp_vecs[$];

    fc_vec_packer #(.BIT_WIDTH(BW), .N(NN)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [BW*NN-1:0] got, input logic [BW*NN-1:0] exp);
        int bad;
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            bad = 0;
            for (int k = NN - 1; k >= 0; k--)
                if (got[k*BW +: BW] !== exp[k*BW +: BW]) bad = k;
            $error("FAIL %s: element %0d got %h expected %h", tag, bad,
                   got[bad*BW +: BW], exp[bad*BW +: BW]);
        end
    endtask

    task automatic chk_guard(input string tag, input int used);
        n_checks++;
        assert (used < GUARD) else begin
            n_errors++;
            $error("FAIL %s: used %0d cycles, limit %0d", tag, used, GUARD);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic tick(input logic v, input logic [BW-1:0] d, input logic l,
                        input logic mr, output logic acc);
        logic             busy;
        logic             exp_err;
        logic [BW*NN-1:0] vec;
        busy    = (exp_vecs.size() != 0);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        acc     = v && !busy;
        exp_err = 1'b0;
        if (busy && mr) begin
            void'(exp_vecs.pop_front());
            n_vec_out++;
        end
        if (acc) begin
            cur_q.push_back(d);
            if (cur_q.size() == NN) begin
                exp_err = !l;
                vec = '0;
                for (int k = 0; k < NN; k++) vec[k*BW +: BW] = cur_q[k];
                exp_vecs.push_back(vec);
                n_vec_in++;
                cur_q.delete();
            end else if (l) begin
                exp_err = 1'b1;
                cur_q.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("err_len", BW'(err_len), BW'(exp_err));
        chk("m_valid", BW'(m_valid), BW'(exp_vecs.size() != 0));
        chk("s_ready", BW'(s_ready), BW'(exp_vecs.size() == 0));
        if (exp_vecs.size() != 0) chk_vec("m_data_hold", m_data, exp_vecs[0]);
    endtask

    // Send `count` words base, base+1, ... ; s_last on the final one if asked.
    task automatic send_words(input logic [BW-1:0] base, input int count,
                              input logic last_on_final, input logic mr);
        int   sent;
        int   used;
        logic acc;
        sent = 0;
        used = 0;
        while (sent < count && used < GUARD) begin
            tick(1'b1, base + BW'(sent), last_on_final && (sent == count - 1), mr, acc);
            if (acc) sent++;
            used++;
        end
        chk_guard("send_words_budget", used);
    endtask

    task automatic idle(input int cycles, input logic mr);
        logic acc;
        for (int i = 0; i < cycles; i++) tick(1'b0, '0, 1'b0, mr, acc);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        cur_q.delete();
        exp_vecs.delete();
        chk("rst_s_ready", BW'(s_ready), 32'd0);
        chk("rst_m_valid", BW'(m_valid), 32'd0);
        chk("rst_err_len", BW'(err_len), 32'd0);
        chk_vec("rst_m_data", m_data, '0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", BW'(s_ready), 32'd1);
    endtask

    initial begin
        logic          acc;
        logic [BW-1:0] w;
        int            used;
        int            sent;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // 1: basic vector 1..120
        do_reset();
        send_words(32'd1, NN, 1'b1, 1'b1);
        chk("t1_valid", BW'(m_valid), 32'd1);
        chk("t1_elem0", m_data[31:0], 32'd1);
        chk("t1_elem119", m_data[3839:3808], 32'd120);
        idle(2, 1'b1);

        // 2: backpressure, s_valid held high while FULL must be ignored
        send_words(32'h100, NN, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 32'hDEAD0000 + BW'(i), 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);
        idle(1, 1'b0);

        // 3: runt of 50 words ending in -5, then a correct vector
        send_words(32'd1, 49, 1'b0, 1'b1);
        tick(1'b1, 32'hFFFFFFFB, 1'b1, 1'b1, acc);
        send_words(32'd1000, NN, 1'b1, 1'b0);
        chk("t3_elem0", m_data[31:0], 32'd1000);
        chk("t3_elem119", m_data[3839:3808], 32'd1119);
        idle(1, 1'b1);

        // 4: 120 words with no s_last
        send_words(32'h5000, NN, 1'b0, 1'b0);
        chk("t4_elem119", m_data[3839:3808], 32'h5077);
        idle(1, 1'b1);

        // 5: random gaps and random backpressure over 20 vectors
        for (int vnum = 0; vnum < 20; vnum++) begin
            sent = 0;
            used = 0;
            while (sent < NN && used < 2 * GUARD) begin
                w = $urandom;
                tick(1'($urandom_range(0, 1)), w, sent == NN - 1,
                     1'($urandom_range(0, 1)), acc);
                if (acc && s_valid) sent++;
                used++;
            end
            n_checks++;
            assert (sent == NN) else begin
                n_errors++;
                $error("FAIL t5_budget: vector %0d sent %0d words, required %0d", vnum, sent, NN);
            end
        end
        used = 0;
        while (exp_vecs.size() != 0 && used < 20) begin
            tick(1'b0, '0, 1'b0, 1'b1, acc);
            used++;
        end

        // 6: reset after 60 accepted words, then a full vector
        send_words(32'hAAAA0000, 60, 1'b0, 1'b1);
        do_reset();
        send_words(32'h7000, NN, 1'b1, 1'b0);
        chk("t6_elem0", m_data[31:0], 32'h7000);
        chk("t6_elem119", m_data[3839:3808], 32'h7077);
        idle(2, 1'b1);

        chk("vectors_in_out", BW'(n_vec_out), BW'(n_vec_in));
        chk("queue_drained", BW'(exp_vecs.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
